instruction_fetch: RTL
======================

Name: instruction_fetch

Overview:
- Byte-serial instruction fetch stage that feeds the instruction decoder.
- Walks the program counter and reads opcode and operand bytes from a byte-wide memory over a req/ack handshake.
- Assembles a 16-bit instruction word plus an optional inline data byte, and presents them with a valid/ready handshake.
- Accepts branch/call/return redirects from the execute stage.

Parameters:
- RESET_PC, 16'h0000, program counter value after reset.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  fetch enable; low = start no new memory transaction.
- mem_req  output  1  memory read request.
- mem_addr  output  16  byte address of the current request.
- mem_ack  input  1  memory accepted the request; mem_rdata valid this cycle.
- mem_rdata  input  8  read data.
- inst_valid  output  1  inst/data/inst_pc hold a complete instruction.
- inst_ready  input  1  downstream accepts the instruction.
- inst  output  16  instruction word {byte@pc, byte@pc+1}.
- data  output  8  inline data byte (byte@pc+2); 8'h00 when not fetched.
- inst_pc  output  16  address of the presented instruction.
- next_pc  output  16  inst_pc + 2, or inst_pc + 3 if a data byte was fetched.
- pc_load  input  1  redirect request.
- pc_load_value  input  16  redirect target.

Behaviour:
- Reset values:
  - State FETCH_HI, pc = RESET_PC.
  - mem_req = 0, mem_addr = RESET_PC.
  - inst_valid = 0; inst, data = 0.
  - inst_pc = RESET_PC, next_pc = RESET_PC + 2.
- States: FETCH_HI, FETCH_LO, FETCH_DATA, HOLD.
- Memory handshake:
  - mem_req and mem_addr are registered and stay stable until a cycle with mem_req & mem_ack.
  - Data is captured in that cycle.
  - The next request may be issued in the following cycle (max one byte per cycle).
  - mem_req is never dropped before ack, except on pc_load.
- FETCH_HI:
  - Issue at pc (only if en).
  - On ack: inst[15:8] <= mem_rdata, go to FETCH_LO with addr pc+1.
- FETCH_LO:
  - On ack: inst[7:0] <= mem_rdata.
  - If inst[15:14] == 2'b10 and inst[10:9] == 2'b01 (one-arg, inline-data source), go to FETCH_DATA with addr pc+2.
  - Otherwise data <= 0 and go to HOLD.
- FETCH_DATA: on ack, data <= mem_rdata, go to HOLD.
- HOLD:
  - inst_valid = 1; mem_req = 0; outputs held stable until inst_ready.
  - On inst_valid & inst_ready: pc <= next_pc, inst_valid <= 0, go to FETCH_HI.
  - The next request is issued the following cycle, so minimum issue-to-issue is 3 cycles for a 2-byte instruction.
- en low:
  - Blocks starting a transaction (mem_req stays 0 in FETCH_* until en).
  - An in-flight request (mem_req already 1) completes normally.
  - Does not affect HOLD.
- pc_load (highest priority, any state):
  - Next cycle pc = pc_load_value, state FETCH_HI, inst_valid = 0, mem_req = 0.
  - Any ack in the same cycle is discarded.
  - If pc_load coincides with an inst_valid & inst_ready handshake, the handshake completes (instruction consumed) but pc takes pc_load_value, not next_pc.
- Address arithmetic is 16-bit modulo: pc 16'hFFFF gives byte addresses FFFF, 0000, 0001; next_pc wraps identically.
- Reset mid-transaction: all state returns to reset values immediately (async); a late ack after reset is ignored because mem_req = 0.

Decomposition:
- Shared cpu_pkg:
  - Fetch state enum.
  - Opcode field constants: ONE_ARG_MASK 16'hC000 / ONE_ARG_VAL 16'h8000; SRC_MASK 16'h0600 / SRC_DATA 16'h0200.
- Used here and by the decoder so the "needs data byte" rule lives in one place.
- No sub-module; single module, registered outputs.

Test Plan:
- Reset release, mem returns 8'h01,8'h00 with ack every cycle -> mem_addr 0000,0001; inst = 16'h0100, data = 8'h00, inst_valid on cycle 3; inst_ready -> next request addr 0002.
- Memory bytes 8'h82,8'h00,8'h5A at 0010 -> inst = 16'h8200, data = 8'h5A, next_pc = 16'h0013, three transactions issued.
- ack delayed 4 cycles on each byte -> mem_req/mem_addr stable throughout; inst assembled correctly; no extra requests.
- inst_ready held low 10 cycles in HOLD -> inst_valid stays 1, outputs unchanged, mem_req = 0; pc_load 16'h1234 mid-FETCH_LO with ack same cycle -> byte discarded, next mem_addr = 1234, inst_valid = 0.
- RESET_PC = 16'hFFFF -> fetch addresses FFFF then 0000, next_pc = 16'h0001.
- rst_n asserted while mem_req pending -> mem_req drops immediately, pc = RESET_PC; en low after reset -> no mem_req until en rises.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch state encoding and the opcode fields that decide
// whether an instruction carries an inline data byte.
package cpu_pkg;

   localparam int unsigned ADDR_W = 16;
   localparam int unsigned BYTE_W = 8;
   localparam int unsigned INST_W = 16;

   typedef enum logic [1:0] {
      FS_FETCH_HI   = 2'd0,
      FS_FETCH_LO   = 2'd1,
      FS_FETCH_DATA = 2'd2,
      FS_HOLD       = 2'd3
   } fetch_state_e;

   localparam logic [INST_W-1:0] ONE_ARG_MASK = 16'hC000;
   localparam logic [INST_W-1:0] ONE_ARG_VAL  = 16'h8000;
   localparam logic [INST_W-1:0] SRC_MASK     = 16'h0600;
   localparam logic [INST_W-1:0] SRC_DATA     = 16'h0200;

   // One-argument instruction whose source is the inline data byte.
   function automatic logic needs_data(input logic [INST_W-1:0] word);
      return ((word & ONE_ARG_MASK) == ONE_ARG_VAL) && ((word & SRC_MASK) == SRC_DATA);
   endfunction

endpackage

// File: rtl/instruction_fetch.sv
// Byte-serial instruction fetch: walks the PC over a req/ack byte memory and
// presents a 16-bit instruction plus optional inline data byte to the decoder.
module instruction_fetch
   import cpu_pkg::*;
#(
   parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_ack,
   input  logic [BYTE_W-1:0] mem_rdata,
   output logic              inst_valid,
   input  logic              inst_ready,
   output logic [INST_W-1:0] inst,
   output logic [BYTE_W-1:0] data,
   output logic [ADDR_W-1:0] inst_pc,
   output logic [ADDR_W-1:0] next_pc,
   input  logic              pc_load,
   input  logic [ADDR_W-1:0] pc_load_value
);

   localparam logic [1:0] FETCH_HI   = FS_FETCH_HI;
   localparam logic [1:0] FETCH_LO   = FS_FETCH_LO;
   localparam logic [1:0] FETCH_DATA = FS_FETCH_DATA;
   localparam logic [1:0] HOLD       = FS_HOLD;

   logic [1:0]        state, state_n;
   logic [ADDR_W-1:0] pc, pc_n;
   logic              mem_req_n;
   logic [ADDR_W-1:0] mem_addr_n;
   logic              inst_valid_n;
   logic [INST_W-1:0] inst_n;
   logic [BYTE_W-1:0] data_n;
   logic [ADDR_W-1:0] inst_pc_n;
   logic [ADDR_W-1:0] next_pc_n;
   logic              xfer;
   logic [INST_W-1:0] lo_word;

   assign xfer    = mem_req & mem_ack;
   assign lo_word = {inst[INST_W-1:BYTE_W], mem_rdata};

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= FETCH_HI;
         pc         <= RESET_PC;
         mem_req    <= 1'b0;
         mem_addr   <= RESET_PC;
         inst_valid <= 1'b0;
         inst       <= '0;
         data       <= '0;
         inst_pc    <= RESET_PC;
         next_pc    <= RESET_PC + ADDR_W'(2);
      end else begin
         state      <= state_n;
         pc         <= pc_n;
         mem_req    <= mem_req_n;
         mem_addr   <= mem_addr_n;
         inst_valid <= inst_valid_n;
         inst       <= inst_n;
         data       <= data_n;
         inst_pc    <= inst_pc_n;
         next_pc    <= next_pc_n;
      end
   end

   // Next-state and next-output logic; a redirect overrides everything.
   always_comb begin
      state_n      = state;
      pc_n         = pc;
      mem_req_n    = mem_req;
      mem_addr_n   = mem_addr;
      inst_valid_n = inst_valid;
      inst_n       = inst;
      data_n       = data;
      inst_pc_n    = inst_pc;
      next_pc_n    = next_pc;

      if (pc_load) begin
         state_n      = FETCH_HI;
         pc_n         = pc_load_value;
         mem_req_n    = 1'b0;
         mem_addr_n   = pc_load_value;
         inst_valid_n = 1'b0;
      end else begin
         case (state)
            FETCH_HI: begin
               if (xfer) begin
                  inst_n     = {mem_rdata, inst[BYTE_W-1:0]};
                  state_n    = FETCH_LO;
                  mem_addr_n = pc + ADDR_W'(1);
                  mem_req_n  = en;
               end else if (!mem_req) begin
                  mem_addr_n = pc;
                  mem_req_n  = en;
               end
            end
            FETCH_LO: begin
               if (xfer) begin
                  inst_n = lo_word;
                  if (needs_data(lo_word)) begin
                     state_n    = FETCH_DATA;
                     mem_addr_n = pc + ADDR_W'(2);
                     mem_req_n  = en;
                  end else begin
                     data_n       = '0;
                     state_n      = HOLD;
                     mem_req_n    = 1'b0;
                     inst_valid_n = 1'b1;
                     inst_pc_n    = pc;
                     next_pc_n    = pc + ADDR_W'(2);
                  end
               end else if (!mem_req) begin
                  mem_req_n = en;
               end
            end
            FETCH_DATA: begin
               if (xfer) begin
                  data_n       = mem_rdata;
                  state_n      = HOLD;
                  mem_req_n    = 1'b0;
                  inst_valid_n = 1'b1;
                  inst_pc_n    = pc;
                  next_pc_n    = pc + ADDR_W'(3);
               end else if (!mem_req) begin
                  mem_req_n = en;
               end
            end
            HOLD: begin
               // Consumed: the next opcode request goes out straight away.
               if (inst_ready) begin
                  pc_n         = next_pc;
                  state_n      = FETCH_HI;
                  inst_valid_n = 1'b0;
                  mem_addr_n   = next_pc;
                  mem_req_n    = en;
               end
            end
            default: begin
               state_n   = FETCH_HI;
               mem_req_n = 1'b0;
            end
         endcase
      end
   end

endmodule
